bidir_bus_ctrl: RTL and testbench



---
 rtl/bidir_bus_ctrl.sv | 139 +++++++++++++
 tb/tb_bidir_bus_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bidir_bus_ctrl.sv
// bidir_bus_ctrl
//   Half-duplex controller for a shared tristate data line. Owns the enable
//   of the external tristate buffer: drives accepted write words for a fixed
//   window, releases the line for a turnaround gap, and samples the line on
//   read requests.
//
//   Optional feature macro: BIDIR_PARITY_EN
//     defined   : bus carries WIDTH+1 bits, bit WIDTH is the even parity of
//                 the write word; rx_perr flags odd parity on captured words.
//     undefined : bus is WIDTH bits, rx_perr is tied 0.
//
//   Ports
//     clk       in   rising-edge clock
//     rst_n     in   asynchronous active-low reset
//     tx_valid  in   write word available
//     tx_data   in   write word [WIDTH]
//     tx_ready  out  write accepted when high with tx_valid (IDLE decode)
//     rx_req    in   level read request, held until rx_valid
//     rx_valid  out  one-cycle pulse, rx_data/rx_perr valid
//     rx_data   out  captured word [WIDTH]
//     rx_perr   out  parity error flag, qualified by rx_valid
//     bus_out   out  tristate buffer data input [BW]
//     bus_oe    out  tristate buffer enable
//     bus_in    in   resolved line value [BW]
module bidir_bus_ctrl #(
  parameter int WIDTH        = 8,
  parameter int DRIVE_CYCLES = 2,
  parameter int TURN_CYCLES  = 1,
  parameter int SAMPLE_DLY   = 2,
`ifdef BIDIR_PARITY_EN
  localparam int BW = WIDTH + 1
`else
  localparam int BW = WIDTH
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  input  logic             rx_req,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_perr,
  output logic [BW-1:0]    bus_out,
  output logic             bus_oe,
  input  logic [BW-1:0]    bus_in
);

  localparam int MAXC_DT = (DRIVE_CYCLES > TURN_CYCLES) ? DRIVE_CYCLES : TURN_CYCLES;
  localparam int MAXC    = (MAXC_DT > SAMPLE_DLY) ? MAXC_DT : SAMPLE_DLY;
  // The counter is loaded with (cycles - 1) and counts down to zero.
  localparam int CW      = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    TURN   = 2'd2,
    SAMPLE = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  assign tx_ready = (state == IDLE);

`ifndef BIDIR_PARITY_EN
  assign rx_perr = 1'b0;
`endif

  // bus_oe is a plain register with async clear, so reset releases the line
  // immediately even in the middle of a drive window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bus_oe   <= 1'b0;
      bus_out  <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
`ifdef BIDIR_PARITY_EN
      rx_perr  <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Writes win over reads when both are pending.
          if (tx_valid) begin
`ifdef BIDIR_PARITY_EN
            bus_out <= {^tx_data, tx_data};
`else
            bus_out <= tx_data;
`endif
            bus_oe  <= 1'b1;
            cnt     <= CW'(DRIVE_CYCLES - 1);
            state   <= DRIVE;
          end else if (rx_req) begin
            cnt   <= CW'(SAMPLE_DLY - 1);
            state <= SAMPLE;
          end
        end
        DRIVE: begin
          if (cnt == '0) begin
            bus_oe <= 1'b0;
            cnt    <= CW'(TURN_CYCLES - 1);
            state  <= TURN;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        TURN: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        SAMPLE: begin
          if (cnt == '0) begin
            rx_data  <= bus_in[WIDTH-1:0];
`ifdef BIDIR_PARITY_EN
            rx_perr  <= ^bus_in;
`endif
            rx_valid <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          bus_oe <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Self-checking bench for bidir_bus_ctrl: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a timestamp-based model.
module tb_bidir_bus_ctrl;

  localparam int WIDTH = 8;
  localparam int D     = 2;
  localparam int T     = 1;
  localparam int S     = 2;
`ifdef BIDIR_PARITY_EN
  localparam int BW = WIDTH + 1;
`else
  localparam int BW = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tx_valid;
  logic [WIDTH-1:0] tx_data;
  logic             tx_ready;
  logic             rx_req;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;
  logic             rx_perr;
  logic [BW-1:0]    bus_out;
  logic             bus_oe;
  logic [BW-1:0]    bus_in;

  bidir_bus_ctrl #(
    .WIDTH(WIDTH), .DRIVE_CYCLES(D), .TURN_CYCLES(T), .SAMPLE_DLY(S)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_req(rx_req), .rx_valid(rx_valid), .rx_data(rx_data), .rx_perr(rx_perr),
    .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [BW-1:0]    exp_bus_out = '0;
  logic [WIDTH-1:0] exp_rx_data = '0;

  typedef struct {
    bit               is_wr;
    logic [WIDTH-1:0] data;
    logic [BW-1:0]    bin;
    logic [BW-1:0]    exp_out;
    logic [WIDTH-1:0] exp_rx;
    bit               exp_perr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] enc(input logic [WIDTH-1:0] d);
`ifdef BIDIR_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  function automatic bit par_err(input logic [BW-1:0] b);
`ifdef BIDIR_PARITY_EN
    return ^b;
`else
    return 1'b0;
`endif
  endfunction

  // Starts from IDLE with the bench 1 time unit past a rising edge.
  task automatic do_write(input logic [WIDTH-1:0] d, input logic [BW-1:0] eo);
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk); #1;
    tx_valid    = 1'b0;
    exp_bus_out = eo;
    for (int k = 0; k <= D + T; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      chk("wr_oe",    32'(bus_oe),   32'(k < D));
      chk("wr_out",   32'(bus_out),  32'(eo));
      chk("wr_ready", 32'(tx_ready), 32'(k == D + T));
    end
  endtask

  task automatic do_read(input logic [BW-1:0] bi, input logic [WIDTH-1:0] erx, input bit eperr);
    rx_req = 1'b1;
    bus_in = bi;
    for (int k = 0; k <= S; k++) begin
      @(posedge clk); #1;
      chk("rd_oe",    32'(bus_oe),   32'd0);
      chk("rd_valid", 32'(rx_valid), 32'(k == S));
      chk("rd_ready", 32'(tx_ready), 32'(k == S));
      if (k == S) begin
        chk("rd_data", 32'(rx_data), 32'(erx));
        chk("rd_perr", 32'(rx_perr), 32'(eperr));
        rx_req = 1'b0;
      end
    end
    exp_rx_data = erx;
    @(posedge clk); #1;
    chk("rd_valid_once", 32'(rx_valid), 32'd0);
    chk("rd_hold",       32'(rx_data),  32'(erx));
  endtask

  initial begin
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    rx_req   = 1'b0;
    bus_in   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_oe",    32'(bus_oe),   32'd0);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_out",   32'(bus_out),  32'd0);
    chk("rst_rx",    32'(rx_data),  32'd0);
    chk("rst_perr",  32'(rx_perr),  32'd0);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("idle_oe",    32'(bus_oe),   32'd0);
      chk("idle_ready", 32'(tx_ready), 32'd1);
      chk("idle_valid", 32'(rx_valid), 32'd0);
    end

    // Directed vector table
    vecs.push_back('{1'b1, 8'hA5, '0,       BW'('hA5), 8'h00, 1'b0});
    vecs.push_back('{1'b0, 8'h00, BW'('h3C), '0,       8'h3C, 1'b0});
    vecs.push_back('{1'b1, 8'hFF, '0,       BW'('hFF), 8'h00, 1'b0});
    vecs.push_back('{1'b1, 8'h00, '0,       BW'('h00), 8'h00, 1'b0});
    vecs.push_back('{1'b0, 8'h00, BW'('h81), '0,       8'h81, 1'b0});
`ifdef BIDIR_PARITY_EN
    vecs.push_back('{1'b1, 8'h07, '0,        BW'('h107), 8'h00, 1'b0});
    vecs.push_back('{1'b0, 8'h00, BW'('h107), '0,        8'h07, 1'b0});
    vecs.push_back('{1'b0, 8'h00, BW'('h007), '0,        8'h07, 1'b1});
`endif
    foreach (vecs[i]) begin
      if (vecs[i].is_wr) do_write(vecs[i].data, vecs[i].exp_out);
      else               do_read(vecs[i].bin, vecs[i].exp_rx, vecs[i].exp_perr);
    end

    // Write and read requested together: write first, read after TURN.
    tx_valid = 1'b1;
    tx_data  = 8'h69;
    rx_req   = 1'b1;
    bus_in   = BW'('h5A);
    for (int k = 0; k <= D + T + 1 + S; k++) begin
      @(posedge clk); #1;
      tx_valid = 1'b0;
      chk("both_oe",    32'(bus_oe),   32'(k < D));
      chk("both_valid", 32'(rx_valid), 32'(k == D + T + 1 + S));
      if (k == D + T + 1 + S) begin
        chk("both_rx", 32'(rx_data), 32'h5A);
        rx_req = 1'b0;
      end
    end
    exp_bus_out = enc(8'h69);
    exp_rx_data = 8'h5A;
    chk("both_out", 32'(bus_out), 32'(exp_bus_out));

    // Randomized run against a timestamp model: every transaction is described
    // by the edge numbers at which it starts, releases the line and ends.
    begin
      int n;
      int free_at, oe_start, oe_end, cap_at;
      bit acc;
      logic [BW-1:0] exp_perr_v;
      logic          exp_perr;
      free_at  = -1;
      oe_start = -100;
      oe_end   = -100;
      cap_at   = -100;
      exp_perr = 1'b0;
      exp_perr_v = '0;
      tx_valid = 1'b0;
      rx_req   = 1'b0;
      for (n = 0; n < 3000; n++) begin
        @(posedge clk);
        acc = 1'b0;
        if (n == cap_at) begin
          exp_rx_data = bus_in[WIDTH-1:0];
          exp_perr    = par_err(bus_in);
        end
        if (n - 1 >= free_at) begin
          if (tx_valid) begin
            acc         = 1'b1;
            oe_start    = n;
            oe_end      = n + D;
            exp_bus_out = enc(tx_data);
            free_at     = n + D + T;
          end else if (rx_req) begin
            cap_at  = n + S;
            free_at = n + S;
          end
        end
        #1;
        chk("rnd_oe",    32'(bus_oe),   32'(n >= oe_start && n < oe_end));
        chk("rnd_ready", 32'(tx_ready), 32'(n >= free_at));
        chk("rnd_valid", 32'(rx_valid), 32'(n == cap_at));
        chk("rnd_out",   32'(bus_out),  32'(exp_bus_out));
        if (n == cap_at) begin
          chk("rnd_rx",   32'(rx_data), 32'(exp_rx_data));
          chk("rnd_perr", 32'(rx_perr), 32'(exp_perr));
        end
        if (acc || !tx_valid) begin
          tx_valid = ($urandom_range(0, 2) == 0);
          tx_data  = WIDTH'($urandom);
        end
        if (n == cap_at)  rx_req = 1'b0;
        else if (!rx_req) rx_req = ($urandom_range(0, 3) == 0);
        bus_in = BW'($urandom);
      end
      tx_valid = 1'b0;
      rx_req   = 1'b0;
      // drain any transaction left in flight
      repeat (D + T + S + 3) @(posedge clk);
      #1;
      chk("drain_ready", 32'(tx_ready), 32'd1);
    end

    // Reset pulsed in the middle of a drive window.
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    chk("mid_oe_before", 32'(bus_oe), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_oe_async",  32'(bus_oe),   32'd0);
    chk("mid_out_rst",   32'(bus_out),  32'd0);
    chk("mid_ready_rst", 32'(tx_ready), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("post_oe",    32'(bus_oe),   32'd0);
      chk("post_ready", 32'(tx_ready), 32'd1);
      chk("post_valid", 32'(rx_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
